fire_scheduler: RTL

//  Driver for the 'fire' selector of a generated synchronous circuit model.

---
 rtl/fire_scheduler_pkg.sv | 21 ++
 rtl/fire_scheduler_if.sv | 28 ++
 rtl/fire_scheduler_rot_prio_pick.sv | 31 +++
 rtl/fire_scheduler.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fire_scheduler_pkg.sv
// Shared codes for the fire scheduler: FSM states, pick modes and the LFSR step.
package fire_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_EVAL = 2'd0,
    ST_FIRE = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [1:0] MODE_RR   = 2'd0;
  localparam logic [1:0] MODE_LFSR = 2'd1;
  localparam logic [1:0] MODE_PRIO = 2'd2;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Galois form, shifting right; taps enter from the top when bit 0 falls out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/fire_scheduler_if.sv
// Signal bundle between the circuit model (master) and the fire scheduler (slave).
interface fire_scheduler_if #(
  parameter int NSIG     = 4,
  parameter int FIREBITS = $clog2(NSIG + 1),
  parameter int CNTW     = 16
);
  logic                enable;
  logic [1:0]          mode;
  logic [NSIG-1:0]     sig_q;
  logic [NSIG-1:0]     sig_precap;
  logic [NSIG-1:0]     input_mask;
  logic [FIREBITS-1:0] fire;
  logic                fire_valid;
  logic [CNTW-1:0]     fire_count;
  logic                hazard;
  logic [FIREBITS-1:0] hazard_idx;
  logic                deadlock;

  modport master (
    output enable, mode, sig_q, sig_precap, input_mask,
    input  fire, fire_valid, fire_count, hazard, hazard_idx, deadlock
  );

  modport slave (
    input  enable, mode, sig_q, sig_precap, input_mask,
    output fire, fire_valid, fire_count, hazard, hazard_idx, deadlock
  );
endinterface

// File: rtl/fire_scheduler_rot_prio_pick.sv
// Rotating priority search: first set request at or after start, wrapping at NSIG.
module rot_prio_pick #(
  parameter int NSIG     = 4,
  parameter int FIREBITS = $clog2(NSIG + 1)
) (
  input  logic [NSIG-1:0]     req,
  input  logic [FIREBITS-1:0] start,
  output logic [FIREBITS-1:0] idx,
  output logic                any
);

  // An out-of-range start is treated as 0 so idx always stays a legal index.
  function automatic int wrap_pos(input logic [FIREBITS-1:0] s, input int off);
    int base;
    int p;
    base = (int'(s) >= NSIG) ? 0 : int'(s);
    p    = base + off;
    if (p >= NSIG) p = p - NSIG;
    return p;
  endfunction

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    idx = FIREBITS'(NSIG);
    any = |req;
    for (int i = NSIG - 1; i >= 0; i--) begin
      if (req[wrap_pos(start, i)]) idx = FIREBITS'(wrap_pos(start, i));
    end
  end

endmodule

// File: rtl/fire_scheduler.sv
// Picks one excited signal per firing for a generated synchronous circuit model,
// and flags withdrawn excitations (hazard) and prolonged quiescence (deadlock).
module fire_scheduler
  import fire_scheduler_pkg::*;
#(
  parameter int          NSIG           = 4,
  parameter int          FIREBITS       = $clog2(NSIG + 1),
  parameter int          DEADLOCK_LIMIT = 8,
  parameter int          CNTW           = 16,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input logic              clk,
  input logic              reset,
  fire_scheduler_if.slave  bus
);

  localparam int                  IDLEW = $clog2(DEADLOCK_LIMIT + 1);
  localparam logic [FIREBITS-1:0] IDLE  = FIREBITS'(NSIG);
  localparam logic [FIREBITS-1:0] LAST  = FIREBITS'(NSIG - 1);

  state_e              state_q, state_d;
  logic [FIREBITS-1:0] fire_q, fire_d;
  logic                fire_valid_q, fire_valid_d;
  logic [CNTW-1:0]     fire_count_q, fire_count_d;
  logic                hazard_q, hazard_d;
  logic [FIREBITS-1:0] hazard_idx_q, hazard_idx_d;
  logic                deadlock_q, deadlock_d;
  logic [FIREBITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [IDLEW-1:0]    idle_cnt_q, idle_cnt_d;
  logic [NSIG-1:0]     prev_exc_q, prev_exc_d;
  logic [FIREBITS-1:0] prev_fired_q, prev_fired_d;

  logic [NSIG-1:0]     excited;
  logic [NSIG-1:0]     withdrawn;
  logic [FIREBITS-1:0] rr_start, lfsr_low, lfsr_fold, lfsr_start, pick_start;
  logic [FIREBITS-1:0] pick_idx, haz_idx;
  logic                pick_any, haz_any;
  logic [IDLEW-1:0]    idle_next;
  logic                limit_hit;

  assign excited   = bus.sig_q ^ bus.sig_precap;
  assign idle_next = idle_cnt_q + IDLEW'(1);
  assign limit_hit = (idle_next == IDLEW'(DEADLOCK_LIMIT));

  assign rr_start   = (rr_ptr_q >= LAST) ? '0 : rr_ptr_q + FIREBITS'(1);
  assign lfsr_low   = lfsr_q[FIREBITS-1:0];
  assign lfsr_fold  = (lfsr_low >= IDLE) ? lfsr_low - IDLE : lfsr_low;
  assign lfsr_start = (lfsr_fold >= IDLE) ? '0 : lfsr_fold;

  always_comb begin
    unique case (bus.mode)
      MODE_RR:   pick_start = rr_start;
      MODE_LFSR: pick_start = lfsr_start;
      default:   pick_start = '0;
    endcase
  end

  // The signal that just fired is expected to drop its excitation; that is not a hazard.
  always_comb begin
    withdrawn = prev_exc_q & ~excited & ~bus.input_mask;
    for (int i = 0; i < NSIG; i++) begin
      if (prev_fired_q == FIREBITS'(i)) withdrawn[i] = 1'b0;
    end
  end

  rot_prio_pick #(.NSIG(NSIG), .FIREBITS(FIREBITS)) u_pick (
    .req   (excited),
    .start (pick_start),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  rot_prio_pick #(.NSIG(NSIG), .FIREBITS(FIREBITS)) u_haz_pick (
    .req   (withdrawn),
    .start ('0),
    .idx   (haz_idx),
    .any   (haz_any)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q      <= ST_EVAL;
      fire_q       <= IDLE;
      fire_valid_q <= 1'b0;
      fire_count_q <= '0;
      hazard_q     <= 1'b0;
      hazard_idx_q <= '0;
      deadlock_q   <= 1'b0;
      rr_ptr_q     <= LAST;
      lfsr_q       <= SEED;
      idle_cnt_q   <= '0;
      prev_exc_q   <= '0;
      prev_fired_q <= IDLE;
    end else begin
      state_q      <= state_d;
      fire_q       <= fire_d;
      fire_valid_q <= fire_valid_d;
      fire_count_q <= fire_count_d;
      hazard_q     <= hazard_d;
      hazard_idx_q <= hazard_idx_d;
      deadlock_q   <= deadlock_d;
      rr_ptr_q     <= rr_ptr_d;
      lfsr_q       <= lfsr_d;
      idle_cnt_q   <= idle_cnt_d;
      prev_exc_q   <= prev_exc_d;
      prev_fired_q <= prev_fired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EVAL: begin
        if (bus.enable) begin
          if (pick_any)       state_d = ST_FIRE;
          else if (limit_hit) state_d = ST_HALT;
        end
      end
      ST_FIRE: state_d = ST_EVAL;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_EVAL;
    endcase
  end

  always_comb begin
    fire_d       = fire_q;
    fire_valid_d = fire_valid_q;
    fire_count_d = fire_count_q;
    hazard_d     = hazard_q;
    hazard_idx_d = hazard_idx_q;
    deadlock_d   = deadlock_q;
    rr_ptr_d     = rr_ptr_q;
    lfsr_d       = lfsr_q;
    idle_cnt_d   = idle_cnt_q;
    prev_exc_d   = prev_exc_q;
    prev_fired_d = prev_fired_q;
    unique case (state_q)
      ST_EVAL: begin
        if (bus.enable) begin
          prev_exc_d = excited;
          lfsr_d     = lfsr_step(lfsr_q);
          if (haz_any && !hazard_q) begin
            hazard_d     = 1'b1;
            hazard_idx_d = haz_idx;
          end
          if (pick_any) begin
            idle_cnt_d   = '0;
            fire_d       = pick_idx;
            fire_valid_d = 1'b1;
          end else begin
            idle_cnt_d = idle_next;
            if (limit_hit) deadlock_d = 1'b1;
          end
        end
      end
      // A started firing always completes, whatever enable does.
      ST_FIRE: begin
        fire_d       = IDLE;
        fire_valid_d = 1'b0;
        if (fire_count_q != '1) fire_count_d = fire_count_q + CNTW'(1);
        prev_fired_d = fire_q;
        if (bus.mode == MODE_RR) rr_ptr_d = fire_q;
      end
      default: ;
    endcase
  end

  assign bus.fire       = fire_q;
  assign bus.fire_valid = fire_valid_q;
  assign bus.fire_count = fire_count_q;
  assign bus.hazard     = hazard_q;
  assign bus.hazard_idx = hazard_idx_q;
  assign bus.deadlock   = deadlock_q;

endmodule
